// File: rtl/dispense_controller.sv
// Dispense controller: turns grant edges from the vending FSM into timed
// vend transactions (motor run, then optional 1 TL and 0.5 TL coin ejects),
// tracks per-product stock, and flags empty and error conditions.
module dispense_controller #(
    parameter int DISP_CYCLES = 50,
    parameter int COIN_PULSE  = 10,
    parameter int COIN_GAP    = 10,
    parameter int STOCK_W     = 4,
    parameter int STOCK_INIT  = 10
) (
    input  logic               Clk,
    input  logic               Req_n,
    input  logic               G_Coke,
    input  logic               G_Water,
    input  logic               Change1,
    input  logic               Change05,
    input  logic               Restock,
    output logic               Motor_Coke,
    output logic               Motor_Water,
    output logic               Eject1,
    output logic               Eject05,
    output logic               Busy,
    output logic [STOCK_W-1:0] Coke_Cnt,
    output logic [STOCK_W-1:0] Water_Cnt,
    output logic               Empty_Coke,
    output logic               Empty_Water,
    output logic               Err
);

    // One shared phase timer covers the longest of the three timed phases.
    localparam int TMAX_A = (DISP_CYCLES > COIN_PULSE) ? DISP_CYCLES : COIN_PULSE;
    localparam int TMAX   = (TMAX_A > COIN_GAP) ? TMAX_A : COIN_GAP;
    localparam int TMR_W  = $clog2(TMAX + 1);

    localparam logic [TMR_W-1:0]   DISP_LAST  = TMR_W'(DISP_CYCLES - 1);
    localparam logic [TMR_W-1:0]   PULSE_LAST = TMR_W'(COIN_PULSE - 1);
    localparam logic [TMR_W-1:0]   GAP_LAST   = TMR_W'(COIN_GAP - 1);
    localparam logic [STOCK_W-1:0] INIT_VAL   = STOCK_W'(STOCK_INIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISP,
        S_EJ1,
        S_GAP1,
        S_EJ05,
        S_GAP05
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q;
    logic               tmr_last;

    // smp_q = {Change05, Change1, G_Water, G_Coke} registered once; the change
    // bits are levels captured with the grant, so only grants keep a previous value.
    logic [3:0]         smp_q;
    logic [1:0]         prev_q;
    logic [1:0]         rise;
    logic               coke_rise, grant_rise, dual_rise;
    logic               start_ok, stock_zero, enter_disp;

    logic               sel_coke_q, c1_q, c05_q;
    logic               err_q, err_d;
    logic [STOCK_W-1:0] stock [2];
    logic [1:0]         sel_vec;

    assign rise       = smp_q[1:0] & ~prev_q;
    assign coke_rise  = rise[0];
    assign grant_rise = |rise;
    assign dual_rise  = &rise;
    assign start_ok   = (state_q == S_IDLE) && grant_rise && !dual_rise;
    assign stock_zero = coke_rise ? (stock[0] == '0) : (stock[1] == '0);
    assign enter_disp = (state_q == S_IDLE) && (state_d == S_DISP);
    assign sel_vec    = {~coke_rise, coke_rise};

    // Input sampling; reset to 1 so levels already high at release give no edge.
    always_ff @(posedge Clk) begin
        if (!Req_n) begin
            smp_q  <= '1;
            prev_q <= '1;
        end else begin
            smp_q  <= {Change05, Change1, G_Water, G_Coke};
            prev_q <= smp_q[1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (!Req_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Last cycle of the current timed phase.
    always_comb begin
        tmr_last = 1'b0;
        case (state_q)
            S_DISP:          tmr_last = (timer_q == DISP_LAST);
            S_EJ1, S_EJ05:   tmr_last = (timer_q == PULSE_LAST);
            S_GAP1, S_GAP05: tmr_last = (timer_q == GAP_LAST);
            default:         tmr_last = 1'b0;
        endcase
    end

    // FSM next state; an empty product skips straight to the coin phases.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    if (!stock_zero)   state_d = S_DISP;
                    else if (smp_q[2]) state_d = S_EJ1;
                    else if (smp_q[3]) state_d = S_EJ05;
                end
            end
            S_DISP: begin
                if (tmr_last) begin
                    if (c1_q)       state_d = S_EJ1;
                    else if (c05_q) state_d = S_EJ05;
                    else            state_d = S_IDLE;
                end
            end
            S_EJ1:   if (tmr_last) state_d = S_GAP1;
            S_GAP1:  if (tmr_last) state_d = c05_q ? S_EJ05 : S_IDLE;
            S_EJ05:  if (tmr_last) state_d = S_GAP05;
            S_GAP05: if (tmr_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Error on: grant edge while busy, both grants at once, or empty product selected.
    always_comb begin
        err_d = (grant_rise && (state_q != S_IDLE))
             || ((state_q == S_IDLE) && dual_rise)
             || (start_ok && stock_zero);
    end

    // Phase timer, transaction capture and registered error pulse.
    always_ff @(posedge Clk) begin
        if (!Req_n) begin
            timer_q    <= '0;
            sel_coke_q <= 1'b0;
            c1_q       <= 1'b0;
            c05_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (state_d != state_q || state_q == S_IDLE) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + 1'b1;
            end
            if (start_ok) begin
                sel_coke_q <= coke_rise;
                c1_q       <= smp_q[2];
                c05_q      <= smp_q[3];
            end
            err_q <= err_d;
        end
    end

    // Per-product stock counters: index 0 coke, index 1 water.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stock
            logic [STOCK_W-1:0] cnt_q;
            // Restock beats a same-cycle decrement; never wraps below zero.
            always_ff @(posedge Clk) begin
                if (!Req_n) begin
                    cnt_q <= INIT_VAL;
                end else if (Restock) begin
                    cnt_q <= INIT_VAL;
                end else if (enter_disp && sel_vec[gi] && (cnt_q != '0)) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
            assign stock[gi] = cnt_q;
        end
    endgenerate

    // Output decode from the registered state.
    always_comb begin
        Motor_Coke  = (state_q == S_DISP) && sel_coke_q;
        Motor_Water = (state_q == S_DISP) && !sel_coke_q;
        Eject1      = (state_q == S_EJ1);
        Eject05     = (state_q == S_EJ05);
        Busy        = (state_q != S_IDLE);
        Err         = err_q;
        Coke_Cnt    = stock[0];
        Water_Cnt   = stock[1];
        Empty_Coke  = (stock[0] == '0);
        Empty_Water = (stock[1] == '0);
    end

endmodule

// File: tb/tb_dispense_controller.sv
// Testbench for dispense_controller: directed scenarios plus randomized
// transactions, each compared cycle by cycle against a timeline model.
module tb_dispense_controller;

    localparam int D  = 50;
    localparam int P  = 10;
    localparam int G  = 10;
    localparam int SI = 10;

    logic       Clk = 1'b0;
    logic       Req_n = 1'b0;
    logic       G_Coke = 1'b0, G_Water = 1'b0, Change1 = 1'b0, Change05 = 1'b0, Restock = 1'b0;
    logic       Motor_Coke, Motor_Water, Eject1, Eject05, Busy, Empty_Coke, Empty_Water, Err;
    logic [3:0] Coke_Cnt, Water_Cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_m [2];
    bit          tail_valid = 1'b0;
    logic [15:0] tail_word  = '0;

    dispense_controller #(
        .DISP_CYCLES(D), .COIN_PULSE(P), .COIN_GAP(G), .STOCK_W(4), .STOCK_INIT(SI)
    ) dut (
        .Clk(Clk), .Req_n(Req_n), .G_Coke(G_Coke), .G_Water(G_Water),
        .Change1(Change1), .Change05(Change05), .Restock(Restock),
        .Motor_Coke(Motor_Coke), .Motor_Water(Motor_Water), .Eject1(Eject1),
        .Eject05(Eject05), .Busy(Busy), .Coke_Cnt(Coke_Cnt), .Water_Cnt(Water_Cnt),
        .Empty_Coke(Empty_Coke), .Empty_Water(Empty_Water), .Err(Err)
    );

    always #5 Clk = ~Clk;

    // Word layout: mc mw e1 e05 busy err empty_c empty_w coke_cnt[3:0] water_cnt[3:0]
    function automatic logic [15:0] pack(input bit mc, input bit mw, input bit e1, input bit e05,
                                         input bit bz, input bit er, input int cc, input int cw);
        logic [3:0] c4, w4;
        c4 = cc[3:0];
        w4 = cw[3:0];
        pack = {mc, mw, e1, e05, bz, er, (cc == 0), (cw == 0), c4, w4};
    endfunction

    function automatic logic [15:0] dut_word();
        dut_word = {Motor_Coke, Motor_Water, Eject1, Eject05, Busy, Err,
                    Empty_Coke, Empty_Water, Coke_Cnt, Water_Cnt};
    endfunction

    // One transaction window: grants driven at t=0..2, outputs sampled every cycle.
    task automatic run_txn(input string name, input bit coke, input bit water, input bit c1,
                           input bit c05, input int restock_at, input int extra_in, input int w_force);
        bit both, started, err_start, mc, mw, e1, e05, bz, er;
        int s, d_eff, l, w, extra, u, b05, cc, cw, busy_cnt;
        logic [15:0] exp_w, act_w;
        both      = coke && water;
        started   = (coke || water) && !both;
        s         = coke ? cnt_m[0] : cnt_m[1];
        err_start = both || (started && s == 0);
        d_eff     = (started && s != 0) ? D : 0;
        l         = started ? d_eff + (c1 ? P + G : 0) + (c05 ? P + G : 0) : 0;
        extra     = extra_in;
        if (extra >= 0 && (!started || extra < 4 || extra > l)) extra = -1;
        w = l + 5;
        if (extra >= 0 && extra + 5 > w) w = extra + 5;
        if (w_force > 0) w = w_force;
        busy_cnt = 0;
        for (int t = 0; t <= w; t++) begin
            u   = t - 2;
            bz  = started && t >= 2 && t < 2 + l;
            mc  = bz && coke && u < d_eff;
            mw  = bz && water && u < d_eff;
            e1  = bz && c1 && u >= d_eff && u < d_eff + P;
            b05 = d_eff + (c1 ? P + G : 0);
            e05 = bz && c05 && u >= b05 && u < b05 + P;
            er  = (t == 2 && err_start) || (extra >= 0 && t == extra + 2);
            cc  = cnt_m[0];
            cw  = cnt_m[1];
            if (d_eff > 0 && t >= 2) begin
                if (coke) cc = cc - 1;
                else      cw = cw - 1;
            end
            if (restock_at >= 0 && t >= restock_at + 1) begin
                cc = SI;
                cw = SI;
            end
            exp_w = pack(mc, mw, e1, e05, bz, er, cc, cw);
            if (t == 0 && tail_valid) exp_w = tail_word;
            if (t < w) begin
                @(posedge Clk);
                #1;
                G_Coke   = (coke && t < 3) || (t == extra);
                G_Water  = water && t < 3;
                Change1  = c1 && t < 3;
                Change05 = c05 && t < 3;
                Restock  = (t == restock_at);
                @(negedge Clk);
                act_w = dut_word();
                n_checks++;
                if (act_w !== exp_w) begin
                    n_fail++;
                    $display("FAIL %s t=%0d outputs got %h expected %h", name, t, act_w, exp_w);
                end
                if (act_w[11]) busy_cnt++;
            end else begin
                tail_word  = exp_w;
                tail_valid = started && (w < 2 + l);
                cnt_m[0]   = cc;
                cnt_m[1]   = cw;
            end
        end
        $display("txn %s coke=%0b water=%0b c1=%0b c05=%0b busy_cycles=%0d stock=%0d/%0d",
                 name, coke, water, c1, c05, busy_cnt, cnt_m[0], cnt_m[1]);
    endtask

    task automatic test_reset();
        logic [15:0] act_w, exp_w;
        exp_w = pack(0, 0, 0, 0, 0, 0, SI, SI);
        for (int t = 0; t < 5; t++) begin
            @(posedge Clk);
            #1;
            Req_n    = 1'b0;
            G_Coke   = 1'($urandom_range(0, 1));
            G_Water  = 1'($urandom_range(0, 1));
            Change1  = 1'($urandom_range(0, 1));
            Change05 = 1'($urandom_range(0, 1));
            @(negedge Clk);
            act_w = dut_word();
            n_checks++;
            if (act_w !== exp_w) begin
                n_fail++;
                $display("FAIL reset_hold t=%0d outputs got %h expected %h", t, act_w, exp_w);
            end
        end
        for (int t = 0; t < 4; t++) begin
            @(posedge Clk);
            #1;
            Req_n = 1'b1; G_Coke = 1'b0; G_Water = 1'b0; Change1 = 1'b0; Change05 = 1'b0;
            @(negedge Clk);
            act_w = dut_word();
            n_checks++;
            if (act_w !== exp_w) begin
                n_fail++;
                $display("FAIL reset_release t=%0d outputs got %h expected %h", t, act_w, exp_w);
            end
        end
        cnt_m[0]   = SI;
        cnt_m[1]   = SI;
        tail_valid = 1'b0;
        $display("txn reset stock=%0d/%0d", cnt_m[0], cnt_m[1]);
    endtask

    task automatic test_water_change();
        run_txn("water_both_coins", 0, 1, 1, 1, -1, -1, 0);
    endtask

    task automatic test_coke_drain();
        for (int i = 0; i < 11; i++) run_txn("coke_drain", 1, 0, 0, 0, -1, -1, 0);
    endtask

    task automatic test_both_edges();
        run_txn("both_grants", 1, 1, 0, 0, -1, -1, 0);
    endtask

    task automatic test_restock_coincident();
        run_txn("restock", 0, 0, 0, 0, 1, -1, 0);
        for (int i = 0; i < 7; i++) run_txn("coke_to_3", 1, 0, 0, 0, -1, -1, 0);
        run_txn("restock_on_dec", 1, 0, 0, 0, 1, -1, 0);
    endtask

    task automatic test_second_edge();
        run_txn("second_edge_disp", 1, 0, 0, 1, -1, 10, 0);
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_first", 0, 1, 1, 0, -1, -1, D + P + G + 1);
        run_txn("b2b_second", 1, 0, 0, 1, -1, -1, 0);
    endtask

    task automatic test_reset_mid();
        int tr;
        logic [15:0] act_w, exp_w;
        tr    = D + 4;
        exp_w = pack(0, 0, 0, 0, 0, 0, SI, SI);
        for (int t = 0; t < D + 30; t++) begin
            @(posedge Clk);
            #1;
            G_Water = 1'b1; Change1 = 1'b1; G_Coke = 1'b0; Change05 = 1'b0; Restock = 1'b0;
            Req_n   = !(t >= tr && t < tr + 2);
            @(negedge Clk);
            if (t == tr) begin
                n_checks++;
                if (Eject1 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL abort_pre_ej1 Eject1 got %b expected 1", Eject1);
                end
            end
            if (t > tr) begin
                act_w = dut_word();
                n_checks++;
                if (act_w !== exp_w) begin
                    n_fail++;
                    $display("FAIL abort_idle t=%0d outputs got %h expected %h", t, act_w, exp_w);
                end
            end
        end
        for (int t = 0; t < 3; t++) begin
            @(posedge Clk);
            #1;
            G_Water = 1'b0; Change1 = 1'b0;
            @(negedge Clk);
            act_w = dut_word();
            n_checks++;
            if (act_w !== exp_w) begin
                n_fail++;
                $display("FAIL abort_drop t=%0d outputs got %h expected %h", t, act_w, exp_w);
            end
        end
        cnt_m[0]   = SI;
        cnt_m[1]   = SI;
        tail_valid = 1'b0;
        $display("txn reset_mid_ej1 stock=%0d/%0d", cnt_m[0], cnt_m[1]);
    endtask

    task automatic test_random();
        int kind, ra, ex;
        bit ck, wt, c1, c05;
        for (int i = 0; i < 30; i++) begin
            kind = int'($urandom_range(0, 9));
            c1   = 1'($urandom_range(0, 1));
            c05  = 1'($urandom_range(0, 1));
            ck   = (kind == 0) || (kind >= 2 && kind < 6);
            wt   = (kind == 0) || (kind >= 6);
            ra   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 80)) : -1;
            ex   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 60)) : -1;
            run_txn("random", ck, wt, c1, c05, ra, ex, 0);
        end
    endtask

    initial begin
        cnt_m[0] = SI;
        cnt_m[1] = SI;
        test_reset();
        test_water_change();
        test_coke_drain();
        test_both_edges();
        test_restock_coincident();
        test_second_edge();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
